// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase CDC handshake transmitter.
// Holds the FSM state encoding, default timeout and counter sizing helper.
package cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 1024;

    // Counter must be able to hold the value TIMEOUT itself (saturation point).
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for bringing an asynchronous level into clk.
// Flops carry no reset; they rely on the device powering up to zero.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // p0: metastability capture, p1: settled copy
    always_ff @(posedge clk) begin
        sync_p0 <= d;
        sync_p1 <= sync_p0;
    end

    assign q = sync_p1;

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake carrying one WIDTH-bit word
// per transfer, with a timeout that parks the block in ERROR until cleared.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             xfer_done,
    output logic             err,
    input  logic             err_clr
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    logic             ack_s;
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_d;
    logic             req_d;
    logic             done_d;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timed_out;

    synchronizer #(.WIDTH(1)) u_ack_sync (
        .clk (clk),
        .d   (ack_in),
        .q   (ack_s)
    );

    assign in_ready  = (state_q == ST_IDLE) && !ack_s;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timed_out = TO_EN && (cnt_q == CNT_LAST);

    // Progress on ack_s is tested before timed_out so a late ack still wins.
    always_comb begin
        state_d = state_q;
        data_d  = data_out;
        req_d   = req_out;
        done_d  = 1'b0;
        err_d   = err;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (timed_out) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ERROR: begin
                req_d = 1'b0;
                if (err_clr && !ack_s) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_out  <= '0;
            req_out   <= 1'b0;
            xfer_done <= 1'b0;
            err       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_out  <= data_d;
            req_out   <= req_d;
            xfer_done <= done_d;
            err       <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: transfer, back-to-back, timeout,
// timeout race, reset mid-handshake and spurious acknowledge.
module tb_cdc_handshake_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       req_out;
    logic       ack_in;
    logic       xfer_done;
    logic       err;
    logic       err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] acc_q[$];
    bit         mon_en = 1'b0;

    cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .req_out   (req_out),
        .ack_in    (ack_in),
        .xfer_done (xfer_done),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && in_valid && in_ready) acc_q.push_back(in_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; ack_in = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({req_out, xfer_done, err, in_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_ctrl: got req/done/err/rdy=%b want 0001", {req_out, xfer_done, err, in_ready});
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL reset_data: got %h want 00", data_out);
        end
    endtask

    task automatic test_basic();
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'h3C;
        n_cmp++;
        if ({req_out, in_ready, data_out} !== {2'b10, 8'hA5}) begin
            n_bad++; $display("FAIL basic_accept: got req=%b rdy=%b data=%h want 1 0 a5", req_out, in_ready, data_out);
        end
        repeat (3) tick();
        ack_in = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (req_out !== 1'b1) begin
            n_bad++; $display("FAIL basic_req_hold: got %b want 1", req_out);
        end
        tick();
        n_cmp++;
        if (req_out !== 1'b0) begin
            n_bad++; $display("FAIL basic_req_fall: got %b want 0", req_out);
        end
        ack_in = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (xfer_done !== 1'b0) begin
            n_bad++; $display("FAIL basic_done_early: got %b want 0", xfer_done);
        end
        tick();
        n_cmp++;
        if ({xfer_done, in_ready, err} !== 3'b110) begin
            n_bad++; $display("FAIL basic_done: got done/rdy/err=%b want 110", {xfer_done, in_ready, err});
        end
        tick();
        n_cmp++;
        if ({xfer_done, data_out} !== {1'b0, 8'hA5}) begin
            n_bad++; $display("FAIL basic_done_pulse: got done=%b data=%h want 0 a5", xfer_done, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        int n;
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
        acc_q.delete();
        mon_en = 1'b1;
        in_data = w[0]; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({req_out, data_out} !== {1'b1, w[i]}) begin
                n_bad++; $display("FAIL b2b_req_%0d: got req=%b data=%h want 1 %h", i, req_out, data_out, w[i]);
            end
            repeat (2) tick();
            ack_in = 1'b1;
            n = 0;
            while (req_out !== 1'b0 && n < 20) begin tick(); n++; end
            n_cmp++;
            if (req_out !== 1'b0) begin
                n_bad++; $display("FAIL b2b_req_fall_%0d: got %b want 0", i, req_out);
            end
            ack_in = 1'b0;
            n = 0;
            while (xfer_done !== 1'b1 && n < 20) begin tick(); n++; end
            n_cmp++;
            if ({xfer_done, in_ready, data_out} !== {2'b11, w[i]}) begin
                n_bad++; $display("FAIL b2b_done_%0d: got done=%b rdy=%b data=%h want 1 1 %h", i, xfer_done, in_ready, data_out, w[i]);
            end
            if (i < 2) in_data = w[i+1];
            else in_valid = 1'b0;
            tick();
        end
        repeat (3) tick();
        mon_en = 1'b0;
        n_cmp++;
        if (acc_q.size() != 3) begin
            n_bad++; $display("FAIL b2b_count: got %0d accepts want 3", acc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= acc_q.size() || acc_q[i] !== w[i]) begin
                n_bad++; $display("FAIL b2b_order_%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, w[i]);
            end
        end
    endtask

    task automatic test_timeout();
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        n_cmp++;
        if ({req_out, err} !== 2'b10) begin
            n_bad++; $display("FAIL to_before: got req/err=%b want 10", {req_out, err});
        end
        tick();
        n_cmp++;
        if ({req_out, err, in_ready} !== 3'b010) begin
            n_bad++; $display("FAIL to_fire: got req/err/rdy=%b want 010", {req_out, err, in_ready});
        end
        repeat (4) tick();
        n_cmp++;
        if ({req_out, err, in_ready} !== 3'b010) begin
            n_bad++; $display("FAIL to_sticky: got req/err/rdy=%b want 010", {req_out, err, in_ready});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if ({err, in_ready, data_out} !== {2'b01, 8'h5A}) begin
            n_bad++; $display("FAIL to_clear: got err=%b rdy=%b data=%h want 0 1 5a", err, in_ready, data_out);
        end
    endtask

    task automatic test_race();
        in_data = 8'h96; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (13) tick();
        ack_in = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({req_out, err} !== 2'b10) begin
            n_bad++; $display("FAIL race_before: got req/err=%b want 10", {req_out, err});
        end
        tick();
        n_cmp++;
        if ({req_out, err} !== 2'b00) begin
            n_bad++; $display("FAIL race_edge: got req/err=%b want 00", {req_out, err});
        end
        ack_in = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({xfer_done, err, in_ready} !== 3'b101) begin
            n_bad++; $display("FAIL race_done: got done/err/rdy=%b want 101", {xfer_done, err, in_ready});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ack_in = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({req_out, in_ready, data_out} !== {2'b00, 8'h00}) begin
            n_bad++; $display("FAIL rmid_reset: got req=%b rdy=%b data=%h want 0 0 00", req_out, in_ready, data_out);
        end
        repeat (3) tick();
        n_cmp++;
        if ({req_out, in_ready, xfer_done} !== 3'b000) begin
            n_bad++; $display("FAIL rmid_wait: got req/rdy/done=%b want 000", {req_out, in_ready, xfer_done});
        end
        ack_in = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rmid_sync1: got rdy=%b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rmid_ready: got rdy=%b want 1", in_ready);
        end
    endtask

    task automatic test_spurious();
        ack_in = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL spur_sync1: got rdy=%b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({in_ready, req_out, xfer_done} !== 3'b000) begin
            n_bad++; $display("FAIL spur_high: got rdy/req/done=%b want 000", {in_ready, req_out, xfer_done});
        end
        ack_in = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL spur_fall1: got rdy=%b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if ({in_ready, req_out, xfer_done, err, data_out} !== {4'b1000, 8'h00}) begin
            n_bad++; $display("FAIL spur_end: got rdy/req/done/err=%b data=%h want 1000 00", {in_ready, req_out, xfer_done, err}, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_race();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bus width in bits, 1..64.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles to wait in REQ or RELEASE; 0 disables the timeout.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_data, input, WIDTH: word to transfer; sampled only on accept.
REQ-006 Port in_valid, input, 1: source has a word.
REQ-007 Port in_ready, output, 1: block can accept; accept = in_valid && in_ready at a rising edge.
REQ-008 Port data_out, output, WIDTH: registered word presented to the far domain.
REQ-009 Port req_out, output, 1: registered four-phase request to the far domain.
REQ-010 Port ack_in, input, 1: asynchronous acknowledge from the far domain.
REQ-011 Port xfer_done, output, 1: one-cycle pulse on handshake completion.
REQ-012 Port err, output, 1: sticky timeout flag.
REQ-013 Port err_clr, input, 1: request to leave the error state.

Function
REQ-014 ack_in SHALL pass through a 2-flop synchronizer; ack_s is ack_in delayed by two rising edges, and the FSM SHALL use only ack_s.
REQ-015 FSM states SHALL be IDLE, REQ, RELEASE and ERROR.
REQ-016 in_ready SHALL equal (state==IDLE && !ack_s), combinationally.
REQ-017 IDLE: on accept, capture in_data into data_out, set req_out=1, go to REQ; otherwise hold.
REQ-018 REQ: hold req_out=1 and data_out stable; on the first edge with ack_s=1, set req_out=0 and go to RELEASE.
REQ-019 RELEASE: hold req_out=0; on the first edge with ack_s=0, go to IDLE and pulse xfer_done=1 for exactly that next cycle.
REQ-020 data_out SHALL change only on accept, and SHALL hold its last value in every other state.
REQ-021 Handshake latency SHALL be: req_out rises 1 edge after accept; req_out falls 1 edge after ack_s rises.
REQ-022 Minimum accept-to-accept spacing SHALL be 2 (req) + 2 (release) synchronizer delays plus far-domain response time; back-to-back accept SHALL be allowed in the cycle after xfer_done.
REQ-023 Timeout counter: clears on entry to REQ and on REQ->RELEASE, increments each cycle in REQ or RELEASE, and saturates at TIMEOUT.
REQ-024 On timeout (TIMEOUT!=0, count==TIMEOUT-1 and no progress that edge): set req_out=0, err=1, go to ERROR.
REQ-025 Simultaneous events: a progress condition on the same edge as timeout SHALL take priority, with no error raised.
REQ-026 ERROR: in_ready=0 and req_out=0; go to IDLE on an edge with err_clr=1 && ack_s=0, clearing err; err_clr SHALL be ignored in all other states.
REQ-027 ack_s rising while in IDLE (spurious) SHALL keep in_ready=0 and have no other effect.

Reset
REQ-028 With rst=1 at an edge: state=IDLE, req_out=0, data_out=0, xfer_done=0, err=0, counter=0.
REQ-029 Reset mid-handshake SHALL drop req_out on the next edge; the block then waits in IDLE with in_ready=0 until ack_s=0.
REQ-030 Synchronizer flops SHALL NOT be reset; they SHALL power up to 0.

Structure
REQ-031 State encodings and the default TIMEOUT constant SHALL live in the shared package cdc_pkg.
REQ-032 A single sub-module, synchronizer (width 1), SHALL instantiate the ack_in path; no other sub-modules.
REQ-033 All outputs except in_ready SHALL be registered.

Verification
REQ-034 Basic transfer: WIDTH=8, in_data=0xA5 with in_valid; far model acks 3 cycles after seeing req -> data_out=0xA5 from accept until the next accept, req_out rises/falls per REQ-021, one xfer_done pulse.
REQ-035 Back-to-back: words 0x01, 0x02, 0x03 with in_valid held high -> exactly three accepts, in order, each after the prior xfer_done.
REQ-036 Timeout: TIMEOUT=16, ack_in held at 0 -> err=1 and req_out=0 16 cycles after req_out rises; in_ready stays 0 until err_clr=1, then returns to 1.
REQ-037 Timeout race: ack arrives so ack_s rises on the timeout edge -> no err, transition to RELEASE.
REQ-038 Reset mid-REQ with ack_in=1 -> req_out=0 next edge; in_ready=0 until 2 cycles after ack_in falls.
REQ-039 Spurious ack: ack_in pulsed in IDLE -> no req change, no xfer_done, in_ready low only while ack_s=1.
